// File: rtl/alu_issue_ctrl_pkg.sv
// Shared definitions for the execute-stage issue controller: micro-op codes,
// ALU one-hot bit positions and the sequencer state encoding.
package alu_issue_ctrl_pkg;

    localparam int XLEN        = 64;
    localparam int UOP_W       = 5;
    localparam int NUM_ALU_OPS = 12;

    localparam logic [4:0] UOP_ADD   = 5'd0;
    localparam logic [4:0] UOP_SUB   = 5'd1;
    localparam logic [4:0] UOP_SLT   = 5'd2;
    localparam logic [4:0] UOP_SLTU  = 5'd3;
    localparam logic [4:0] UOP_AND   = 5'd4;
    localparam logic [4:0] UOP_OR    = 5'd5;
    localparam logic [4:0] UOP_XOR   = 5'd6;
    localparam logic [4:0] UOP_SLL   = 5'd7;
    localparam logic [4:0] UOP_SRL   = 5'd8;
    localparam logic [4:0] UOP_SRA   = 5'd9;
    localparam logic [4:0] UOP_LUI   = 5'd10;
    localparam logic [4:0] UOP_JAL   = 5'd11;
    localparam logic [4:0] UOP_DIV   = 5'd12;
    localparam logic [4:0] UOP_DIVU  = 5'd13;
    localparam logic [4:0] UOP_REM   = 5'd14;
    localparam logic [4:0] UOP_REMU  = 5'd15;
    localparam logic [4:0] UOP_STORE = 5'd16;

    // Bit positions inside the ALU one-hot op vector
    localparam int ALU_ADD = 0;
    localparam int ALU_SUB = 1;
    localparam int ALU_JAL = 11;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_EXEC     = 3'd1,
        ST_DIV_INIT = 3'd2,
        ST_DIV_LOOP = 3'd3,
        ST_DIV_FIX  = 3'd4,
        ST_DONE     = 3'd5
    } state_t;

    function automatic logic [NUM_ALU_OPS-1:0] uop_onehot(input logic [4:0] uop);
        logic [NUM_ALU_OPS-1:0] oh;
        oh = '0;
        if (uop <= UOP_JAL) begin
            oh = NUM_ALU_OPS'(1) << uop;
        end
        return oh;
    endfunction

endpackage

// File: rtl/alu_div_core.sv
// Iterative restoring divider on unsigned magnitudes: one quotient bit per cycle,
// 64 steps (32 in word mode). last_o is high during the final step.
module alu_div_core
    import alu_issue_ctrl_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            start_i,
    input  logic            kill_i,
    input  logic            word_i,
    input  logic [XLEN-1:0] dividend_i,
    input  logic [XLEN-1:0] divisor_i,
    output logic            last_o,
    output logic [XLEN-1:0] quot_o,
    output logic [XLEN-1:0] rem_o
);

    logic [XLEN-1:0] rem_q;
    logic [XLEN-1:0] quot_q;
    logic [XLEN-1:0] dvs_q;
    logic [6:0]      cnt_q;
    logic            run_q;
    logic            word_q;
    logic [XLEN:0]   trial;
    logic [6:0]      last_cnt;

    // Partial remainder is always below the divisor, so the shifted trial fits in XLEN+1 bits
    assign trial    = {rem_q, quot_q[XLEN-1]} - {1'b0, dvs_q};
    assign last_cnt = word_q ? 7'd31 : 7'd63;
    assign last_o   = run_q && (cnt_q == last_cnt);
    assign quot_o   = quot_q;
    assign rem_o    = rem_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            rem_q  <= '0;
            quot_q <= '0;
            dvs_q  <= '0;
            cnt_q  <= '0;
            run_q  <= 1'b0;
            word_q <= 1'b0;
        end else if (kill_i) begin
            run_q <= 1'b0;
        end else if (start_i) begin
            rem_q  <= '0;
            // Word mode left-aligns the 32-bit dividend so the same shift path applies
            quot_q <= word_i ? {dividend_i[31:0], 32'b0} : dividend_i;
            dvs_q  <= divisor_i;
            cnt_q  <= '0;
            run_q  <= 1'b1;
            word_q <= word_i;
        end else if (run_q) begin
            if (!trial[XLEN]) begin
                rem_q  <= trial[XLEN-1:0];
                quot_q <= {quot_q[XLEN-2:0], 1'b1};
            end else begin
                rem_q  <= {rem_q[XLEN-2:0], quot_q[XLEN-1]};
                quot_q <= {quot_q[XLEN-2:0], 1'b0};
            end
            cnt_q <= cnt_q + 7'd1;
            if (last_o) begin
                run_q <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Execute-stage sequencer: drives the integer ALU for single-cycle ops and runs
// the iterative divider with RISC-V corner-case handling; result held until out_ready.
module alu_issue_ctrl #(
    parameter int XLEN  = 64,
    parameter int UOP_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [UOP_W-1:0] in_uop,
    input  logic             in_w,
    input  logic [2:0]       in_bhwd,
    input  logic [XLEN-1:0]  in_src1,
    input  logic [XLEN-1:0]  in_src2,
    input  logic [XLEN-1:0]  in_imm,
    output logic [11:0]      alu_op,
    output logic [2:0]       alu_s_bhwd,
    output logic             alu_s_check,
    output logic             alu_w_check,
    output logic [XLEN-1:0]  alu_src1,
    output logic [XLEN-1:0]  alu_src2,
    output logic [XLEN-1:0]  alu_imm,
    input  logic [XLEN-1:0]  alu_data_rd,
    input  logic [XLEN-1:0]  alu_src2_out,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_result,
    output logic [XLEN-1:0]  out_sdata,
    output logic             busy
);
    import alu_issue_ctrl_pkg::*;

    state_t           state_q;
    logic [UOP_W-1:0] uop_q;
    logic             w_q;
    logic             neg_q_q;
    logic             neg_r_q;
    logic             corner_q;
    logic [XLEN-1:0]  cq_q;
    logic [XLEN-1:0]  cr_q;

    logic             div_signed;
    logic             div_is_rem;
    logic [XLEN-1:0]  a_ext_d;
    logic [XLEN-1:0]  b_ext_d;
    logic [XLEN-1:0]  mag_a_d;
    logic [XLEN-1:0]  mag_b_d;
    logic [XLEN-1:0]  min_neg_d;
    logic             neg_a_d;
    logic             neg_b_d;
    logic             div_zero_d;
    logic             div_ovf_d;
    logic             div_start;
    logic             div_last;
    logic [XLEN-1:0]  div_quot;
    logic [XLEN-1:0]  div_rem;
    logic [XLEN-1:0]  fix_q_d;
    logic [XLEN-1:0]  fix_r_d;
    logic [XLEN-1:0]  fix_sel_d;
    logic [XLEN-1:0]  fix_res_d;

    assign in_ready   = (state_q == ST_IDLE);
    assign busy       = (state_q != ST_IDLE);
    assign div_signed = (uop_q == UOP_DIV) || (uop_q == UOP_REM);
    assign div_is_rem = (uop_q == UOP_REM) || (uop_q == UOP_REMU);

    // Operand formation works on the latched ALU operand copies, which are frozen until IDLE
    always_comb begin
        a_ext_d = alu_src1;
        b_ext_d = alu_src2;
        if (w_q) begin
            a_ext_d = div_signed ? {{(XLEN-32){alu_src1[31]}}, alu_src1[31:0]}
                                 : {{(XLEN-32){1'b0}}, alu_src1[31:0]};
            b_ext_d = div_signed ? {{(XLEN-32){alu_src2[31]}}, alu_src2[31:0]}
                                 : {{(XLEN-32){1'b0}}, alu_src2[31:0]};
        end
        neg_a_d    = div_signed & a_ext_d[XLEN-1];
        neg_b_d    = div_signed & b_ext_d[XLEN-1];
        mag_a_d    = neg_a_d ? -a_ext_d : a_ext_d;
        mag_b_d    = neg_b_d ? -b_ext_d : b_ext_d;
        min_neg_d  = w_q ? {{(XLEN-31){1'b1}}, 31'b0} : {1'b1, {(XLEN-1){1'b0}}};
        div_zero_d = (b_ext_d == '0);
        div_ovf_d  = div_signed && (a_ext_d == min_neg_d) && (&b_ext_d);
    end

    assign div_start = (state_q == ST_DIV_INIT) && !div_zero_d && !div_ovf_d && !flush;

    alu_div_core u_div (
        .clk        (clk),
        .rst        (rst),
        .start_i    (div_start),
        .kill_i     (flush),
        .word_i     (w_q),
        .dividend_i (mag_a_d),
        .divisor_i  (mag_b_d),
        .last_o     (div_last),
        .quot_o     (div_quot),
        .rem_o      (div_rem)
    );

    // Corner cases bypass sign fix-up: their values are already architecturally final
    always_comb begin
        fix_q_d = neg_q_q ? -div_quot : div_quot;
        fix_r_d = neg_r_q ? -div_rem  : div_rem;
        if (corner_q) begin
            fix_q_d = cq_q;
            fix_r_d = cr_q;
        end
        fix_sel_d = div_is_rem ? fix_r_d : fix_q_d;
        fix_res_d = w_q ? {{(XLEN-32){fix_sel_d[31]}}, fix_sel_d[31:0]} : fix_sel_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            uop_q       <= '0;
            w_q         <= 1'b0;
            neg_q_q     <= 1'b0;
            neg_r_q     <= 1'b0;
            corner_q    <= 1'b0;
            cq_q        <= '0;
            cr_q        <= '0;
            alu_op      <= '0;
            alu_s_bhwd  <= '0;
            alu_s_check <= 1'b0;
            alu_w_check <= 1'b0;
            alu_src1    <= '0;
            alu_src2    <= '0;
            alu_imm     <= '0;
            out_valid   <= 1'b0;
            out_result  <= '0;
            out_sdata   <= '0;
        end else if (flush) begin
            state_q     <= ST_IDLE;
            alu_op      <= '0;
            alu_s_bhwd  <= '0;
            alu_s_check <= 1'b0;
            alu_w_check <= 1'b0;
            out_valid   <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (in_valid) begin
                        uop_q    <= in_uop;
                        w_q      <= in_w;
                        alu_src1 <= in_src1;
                        alu_src2 <= in_src2;
                        alu_imm  <= in_imm;
                        if (in_uop <= UOP_JAL || in_uop == UOP_STORE) begin
                            state_q     <= ST_EXEC;
                            alu_op      <= (in_uop == UOP_STORE) ? 12'(1) << ALU_ADD
                                                                 : uop_onehot(in_uop);
                            alu_s_check <= (in_uop == UOP_STORE);
                            alu_s_bhwd  <= (in_uop == UOP_STORE) ? in_bhwd : 3'b000;
                            alu_w_check <= in_w;
                        end else if (in_uop <= UOP_REMU) begin
                            state_q <= ST_DIV_INIT;
                        end else begin
                            state_q    <= ST_DONE;
                            out_result <= '0;
                            out_sdata  <= '0;
                            out_valid  <= 1'b1;
                        end
                    end
                end
                ST_EXEC: begin
                    out_result  <= alu_data_rd;
                    out_sdata   <= alu_src2_out;
                    out_valid   <= 1'b1;
                    alu_op      <= '0;
                    alu_s_bhwd  <= '0;
                    alu_s_check <= 1'b0;
                    alu_w_check <= 1'b0;
                    state_q     <= ST_DONE;
                end
                ST_DIV_INIT: begin
                    neg_q_q <= neg_a_d ^ neg_b_d;
                    neg_r_q <= neg_a_d;
                    if (div_zero_d) begin
                        corner_q <= 1'b1;
                        cq_q     <= '1;
                        cr_q     <= a_ext_d;
                        state_q  <= ST_DIV_FIX;
                    end else if (div_ovf_d) begin
                        corner_q <= 1'b1;
                        cq_q     <= a_ext_d;
                        cr_q     <= '0;
                        state_q  <= ST_DIV_FIX;
                    end else begin
                        corner_q <= 1'b0;
                        state_q  <= ST_DIV_LOOP;
                    end
                end
                ST_DIV_LOOP: begin
                    if (div_last) begin
                        state_q <= ST_DIV_FIX;
                    end
                end
                ST_DIV_FIX: begin
                    out_result <= fix_res_d;
                    out_sdata  <= '0;
                    out_valid  <= 1'b1;
                    state_q    <= ST_DONE;
                end
                ST_DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state_q   <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Bench for alu_issue_ctrl: attached ALU model, directed vector table,
// multi-cycle flush/reset/backpressure sequences and randomized ops against a reference.
module tb_alu_issue_ctrl;

    logic        clk = 1'b0;
    logic        rst, flush, in_valid, in_ready, in_w, out_valid, out_ready, busy;
    logic        alu_s_check, alu_w_check;
    logic [4:0]  in_uop;
    logic [2:0]  in_bhwd, alu_s_bhwd;
    logic [11:0] alu_op;
    logic [63:0] in_src1, in_src2, in_imm;
    logic [63:0] alu_src1, alu_src2, alu_imm, alu_data_rd, alu_src2_out;
    logic [63:0] out_result, out_sdata;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    alu_issue_ctrl dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_uop(in_uop), .in_w(in_w),
        .in_bhwd(in_bhwd), .in_src1(in_src1), .in_src2(in_src2), .in_imm(in_imm),
        .alu_op(alu_op), .alu_s_bhwd(alu_s_bhwd), .alu_s_check(alu_s_check),
        .alu_w_check(alu_w_check), .alu_src1(alu_src1), .alu_src2(alu_src2),
        .alu_imm(alu_imm), .alu_data_rd(alu_data_rd), .alu_src2_out(alu_src2_out),
        .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
        .out_sdata(out_sdata), .busy(busy)
    );

    function automatic logic [63:0] alu_fn(input logic [11:0] op, input logic s_chk,
                                           input logic w, input logic [63:0] a, b, imm);
        logic [63:0] r;
        r = '0;
        if (s_chk) return a + imm;
        case (1'b1)
            op[0]:   r = a + b;
            op[1]:   r = a - b;
            op[2]:   r = {63'b0, $signed(a) < $signed(b)};
            op[3]:   r = {63'b0, a < b};
            op[4]:   r = a & b;
            op[5]:   r = a | b;
            op[6]:   r = a ^ b;
            op[7]:   r = a << b[5:0];
            op[8]:   r = a >> b[5:0];
            op[9]:   r = $unsigned($signed(a) >>> b[5:0]);
            op[10]:  r = imm;
            op[11]:  r = a + 64'd4;
            default: r = '0;
        endcase
        if (w) r = {{32{r[31]}}, r[31:0]};
        return r;
    endfunction

    function automatic logic [63:0] rep(input logic [2:0] bh, input logic [63:0] b);
        if (bh[2]) return {8{b[7:0]}};
        if (bh[1]) return {4{b[15:0]}};
        if (bh[0]) return {2{b[31:0]}};
        return b;
    endfunction

    always_comb begin
        alu_data_rd  = alu_fn(alu_op, alu_s_check, alu_w_check, alu_src1, alu_src2, alu_imm);
        alu_src2_out = rep(alu_s_bhwd, alu_src2);
    end

    // Reference: RISC-V division semantics computed with native arithmetic
    function automatic void ref_op(input logic [4:0] u, input logic w, input logic [2:0] bh,
                                   input logic [63:0] a, b, imm,
                                   output logic [63:0] res, output logic [63:0] sd,
                                   output bit chk_sd, output int lat);
        bit sgn, isrem;
        logic [31:0] a32, b32, q32, r32;
        logic [63:0] q64, r64;
        sgn = (u == 5'd12) || (u == 5'd14);
        isrem = (u == 5'd14) || (u == 5'd15);
        a32 = a[31:0];
        b32 = b[31:0];
        res = '0; sd = '0; chk_sd = 1'b0; lat = 2;
        if (u <= 5'd11) begin
            res = alu_fn(12'b1 << u, 1'b0, w, a, b, imm);
            sd = b; chk_sd = 1'b1;
        end else if (u == 5'd16) begin
            res = a + imm;
            sd = rep(bh, b); chk_sd = 1'b1;
        end else if (u > 5'd16) begin
            chk_sd = 1'b1; lat = 1;
        end else if (w) begin
            lat = 35;
            if (b32 == 32'd0) begin
                q32 = '1; r32 = a32; lat = 3;
            end else if (sgn && a32 == 32'h8000_0000 && b32 == 32'hFFFF_FFFF) begin
                q32 = a32; r32 = '0; lat = 3;
            end else if (sgn) begin
                q32 = $signed(a32) / $signed(b32);
                r32 = $signed(a32) % $signed(b32);
            end else begin
                q32 = a32 / b32;
                r32 = a32 % b32;
            end
            res = isrem ? {{32{r32[31]}}, r32} : {{32{q32[31]}}, q32};
        end else begin
            lat = 67;
            if (b == 64'd0) begin
                q64 = '1; r64 = a; lat = 3;
            end else if (sgn && a == 64'h8000_0000_0000_0000 && b == '1) begin
                q64 = a; r64 = '0; lat = 3;
            end else if (sgn) begin
                q64 = $signed(a) / $signed(b);
                r64 = $signed(a) % $signed(b);
            end else begin
                q64 = a / b;
                r64 = a % b;
            end
            res = isrem ? r64 : q64;
        end
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    task automatic run_op(input string nm, input logic [4:0] u, input logic w,
                          input logic [2:0] bh, input logic [63:0] a, b, imm,
                          input logic [63:0] exp_res, exp_sd, input bit chk_sd,
                          input int exp_lat, input int hold);
        int lat;
        bit stable;
        logic [11:0] exp_op;
        logic [63:0] held;
        exp_op = (u <= 5'd11) ? (12'b1 << u) : (u == 5'd16) ? 12'b1 : 12'b0;
        @(negedge clk);
        chk({nm, "_in_ready"}, {63'b0, in_ready}, 64'd1);
        in_valid = 1'b1; in_uop = u; in_w = w; in_bhwd = bh;
        in_src1 = a; in_src2 = b; in_imm = imm;
        @(negedge clk);
        in_valid = 1'b0;
        in_src1 = ~a; in_src2 = ~b; in_imm = ~imm;
        lat = 1;
        chk({nm, "_alu_op"}, {52'b0, alu_op}, {52'b0, exp_op});
        while (!out_valid && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        chk({nm, "_latency"}, 64'(lat), 64'(exp_lat));
        chk({nm, "_result"}, out_result, exp_res);
        if (chk_sd) chk({nm, "_sdata"}, out_sdata, exp_sd);
        if (hold > 0) begin
            stable = 1'b1;
            held = out_result;
            repeat (hold) begin
                @(negedge clk);
                if (out_result !== held || !out_valid || in_ready) stable = 1'b0;
            end
            chk({nm, "_hold_stable"}, {63'b0, stable}, 64'd1);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk({nm, "_release"}, {62'b0, in_ready, out_valid}, 64'b10);
    endtask

    function automatic logic [63:0] rnd_opnd();
        case ($urandom_range(0, 5))
            0:       return 64'd0;
            1:       return '1;
            2:       return 64'h8000_0000_0000_0000;
            3:       return 64'($urandom_range(0, 50));
            4:       return {{32{1'b1}}, $urandom()};
            default: return {$urandom(), $urandom()};
        endcase
    endfunction

    typedef struct {
        logic [4:0]  uop;
        logic        w;
        logic [2:0]  bhwd;
        logic [63:0] s1, s2, imm, res, sd;
        bit          chk_sd;
        int          lat;
    } vec_t;

    vec_t tbl[12];

    initial begin
        logic [63:0] r_res, r_sd;
        bit r_chk;
        int r_lat;
        bit seen;

        tbl[0]  = '{5'd0,  1'b0, 3'b000, 64'd5, 64'd7, 64'd0, 64'd12, 64'd7, 1'b1, 2};
        tbl[1]  = '{5'd16, 1'b0, 3'b100, 64'h8000_0000, 64'hAB, 64'h10, 64'h8000_0010,
                    64'hABAB_ABAB_ABAB_ABAB, 1'b1, 2};
        tbl[2]  = '{5'd12, 1'b0, 3'b000, -64'sd7, 64'd2, 64'd0, -64'sd3, 64'd0, 1'b0, 67};
        tbl[3]  = '{5'd14, 1'b0, 3'b000, -64'sd7, 64'd2, 64'd0, -64'sd1, 64'd0, 1'b0, 67};
        tbl[4]  = '{5'd12, 1'b1, 3'b000, 64'hFFFF_FFFF_8000_0000, '1, 64'd0,
                    64'hFFFF_FFFF_8000_0000, 64'd0, 1'b0, 3};
        tbl[5]  = '{5'd13, 1'b0, 3'b000, 64'd12345, 64'd0, 64'd0, '1, 64'd0, 1'b0, 3};
        tbl[6]  = '{5'd15, 1'b0, 3'b000, 64'h1234, 64'd0, 64'd0, 64'h1234, 64'd0, 1'b0, 3};
        tbl[7]  = '{5'd13, 1'b1, 3'b000, 64'd100, 64'd7, 64'd0, 64'd14, 64'd0, 1'b0, 35};
        tbl[8]  = '{5'd14, 1'b1, 3'b000, -64'sd7, 64'd2, 64'd0, -64'sd1, 64'd0, 1'b0, 35};
        tbl[9]  = '{5'd12, 1'b0, 3'b000, 64'h8000_0000_0000_0000, '1, 64'd0,
                    64'h8000_0000_0000_0000, 64'd0, 1'b0, 3};
        tbl[10] = '{5'd20, 1'b0, 3'b000, 64'd9, 64'd9, 64'd9, 64'd0, 64'd0, 1'b1, 1};
        tbl[11] = '{5'd1,  1'b0, 3'b000, 64'd5, 64'd7, 64'd0, -64'sd2, 64'd7, 1'b1, 2};

        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_uop = '0; in_w = 1'b0; in_bhwd = '0; in_src1 = '0; in_src2 = '0; in_imm = '0;
        repeat (3) @(negedge clk);
        chk("reset_alu_op", {52'b0, alu_op}, 64'd0);
        chk("reset_ctrl", {59'b0, alu_s_bhwd, alu_s_check, alu_w_check}, 64'd0);
        chk("reset_operands", alu_src1 | alu_src2 | alu_imm, 64'd0);
        chk("reset_out", {63'b0, out_valid}, 64'd0);
        chk("reset_result", out_result | out_sdata, 64'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("post_reset_in_ready", {62'b0, in_ready, busy}, 64'b10);

        for (int i = 0; i < 12; i++) begin
            run_op($sformatf("vec%0d", i), tbl[i].uop, tbl[i].w, tbl[i].bhwd, tbl[i].s1,
                   tbl[i].s2, tbl[i].imm, tbl[i].res, tbl[i].sd, tbl[i].chk_sd, tbl[i].lat,
                   (i == 1) ? 10 : 0);
        end

        // flush while the divider is iterating
        @(negedge clk);
        in_valid = 1'b1; in_uop = 5'd12; in_w = 1'b0; in_src1 = 64'd1000; in_src2 = 64'd3;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (10) @(negedge clk);
        chk("flush_busy_before", {63'b0, busy}, 64'd1);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("flush_idle", {62'b0, in_ready, busy}, 64'b10);
        seen = 1'b0;
        repeat (80) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        chk("flush_no_valid", {63'b0, seen}, 64'd0);

        // flush together with in_valid in IDLE: op must be dropped
        in_valid = 1'b1; flush = 1'b1; in_uop = 5'd0;
        @(negedge clk);
        in_valid = 1'b0; flush = 1'b0;
        chk("flush_blocks_accept", {63'b0, busy}, 64'd0);

        // reset during EXEC
        in_valid = 1'b1; in_uop = 5'd0; in_src1 = 64'd3; in_src2 = 64'd4;
        @(negedge clk);
        in_valid = 1'b0;
        chk("exec_alu_op", {52'b0, alu_op}, 64'd1);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_exec_outputs", {51'b0, alu_op, out_valid}, 64'd0);
        chk("rst_exec_data", out_result | alu_src1 | alu_src2, 64'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_exec_in_ready", {63'b0, in_ready}, 64'd1);

        for (int n = 0; n < 40; n++) begin
            logic [4:0] u;
            logic w;
            logic [2:0] bh;
            logic [63:0] a, b, imm;
            u = 5'($urandom_range(0, 17));
            if (u == 5'd17) u = 5'($urandom_range(17, 31));
            w = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 3))
                0:       bh = 3'b000;
                1:       bh = 3'b001;
                2:       bh = 3'b010;
                default: bh = 3'b100;
            endcase
            a = rnd_opnd();
            b = rnd_opnd();
            imm = {$urandom(), $urandom()};
            ref_op(u, w, bh, a, b, imm, r_res, r_sd, r_chk, r_lat);
            run_op($sformatf("rnd%0d_u%0d", n, u), u, w, bh, a, b, imm, r_res, r_sd,
                   r_chk, r_lat, $urandom_range(0, 3));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_issue_ctrl.md
Name: alu_issue_ctrl

Overview:
- Execute-stage sequencer for the RV64 integer ALU and an internal iterative divider.
- Accepts one decoded micro-op per handshake from ID.
- Single-cycle ALU ops: drives the ALU's one-hot op/s_bhwd/s_check/w_check controls from registered state and captures data_rd.
- DIV/DIVU/REM/REMU (and W forms): runs a shift-subtract FSM and applies RISC-V corner-case rules.
- Presents the result to MEM/WB over a valid/ready handshake.

Parameters:
- XLEN, 64, datapath width.
- UOP_W, 5, micro-op code width.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- flush  in  1  abort in-flight op (pipeline redirect)
- in_valid  in  1  upstream op valid
- in_ready  out  1  controller can accept
- in_uop  in  5  0..11 = ALU op bit index (add,sub,slt,sltu,and,or,xor,sll,srl,sra,lui,jal); 12 DIV, 13 DIVU, 14 REM, 15 REMU, 16 STORE-addr
- in_w  in  1  word (32-bit) variant
- in_bhwd  in  3  store size one-hot (b,h,w; 0 = d)
- in_src1, in_src2, in_imm  in  64 each  operands
- alu_op  out  12  one-hot ALU op
- alu_s_bhwd  out  3  store size to ALU
- alu_s_check  out  1  address mode (src1+imm)
- alu_w_check  out  1  word mode
- alu_src1, alu_src2, alu_imm  out  64 each  latched operands to ALU
- alu_data_rd  in  64  ALU result
- alu_src2_out  in  64  ALU store-data replicate
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts
- out_result  out  64  rd value / store address
- out_sdata  out  64  store data
- busy  out  1  state != IDLE

Behaviour:
- States: IDLE, EXEC, DIV_INIT, DIV_LOOP, DIV_FIX, DONE.
- Reset: state IDLE. All registered outputs are 0: alu_op, alu_* controls, operands, out_valid, out_result, out_sdata.
- in_ready = (state==IDLE); it is 1 in the first cycle after rst deasserts.
- Accept when in_valid & in_ready:
  - Latch uop, w, bhwd and operands.
  - uop 0..11 or 16: go to EXEC.
  - uop 12..15: go to DIV_INIT.
  - uop >16: go to DONE with result 0 (illegal, no trap here).
- EXEC (1 cycle):
  - alu_op = one-hot of uop; STORE drives op_add with s_check=1.
  - alu_w_check = w; alu_s_bhwd = bhwd for STORE, else 0.
  - Capture alu_data_rd into out_result and alu_src2_out into out_sdata; go to DONE.
- alu_op is 0 in every state except EXEC.
- ALU op latency: accept at cycle N, out_valid=1 at N+2.
- DIV_INIT:
  - Form operands. W variant: low 32 bits, sign-extended (signed ops) or zero-extended (unsigned).
  - Signed ops take absolute values and record quotient/remainder signs.
  - Check corner cases:
    - Divisor 0: Q = all ones, R = dividend.
    - Signed overflow (most-negative / -1): Q = dividend, R = 0.
  - Either corner case goes straight to DIV_FIX with those values; otherwise go to DIV_LOOP, count=0.
- DIV_LOOP:
  - One quotient bit per cycle, restoring shift-subtract.
  - 64 iterations, or 32 when w=1; count is 7 bits.
  - Exit to DIV_FIX after the last iteration.
- DIV_FIX:
  - Apply signs: Q negated if signs differ; R takes the dividend's sign.
  - Select Q (DIV/DIVU) or R (REM/REMU).
  - W variant: sign-extend bit 31 to 64.
  - Go to DONE.
- DIV latency: 2 + iterations + 1 cycles to out_valid (67 for 64-bit, 35 for W); corner cases take 3.
- DONE: out_valid=1 and out_result held stable until out_ready. On out_valid & out_ready go to IDLE. No same-cycle re-accept; throughput is 1 op per 3 cycles minimum.
- flush: highest priority after rst. Any state goes to IDLE next cycle, out_valid drops, and the in-flight result is discarded. flush and in_valid in the same IDLE cycle: the op is not accepted.
- Operands must not change while state != IDLE; the latched copies guarantee this.

Decomposition:
- Shared package: uop code constants (UOP_ADD..UOP_JAL, UOP_DIV, UOP_DIVU, UOP_REM, UOP_REMU, UOP_STORE), ALU op bit positions, state enum, XLEN.
- One natural sub-module: alu_div_core (iterative restoring divider datapath: remainder/quotient registers, counter, start/done). The FSM and ALU sequencing stay in alu_issue_ctrl.

Test Plan:
- ADD:
  - Stimulus: uop=0, src1=5, src2=7, ALU model attached.
  - Response: alu_op=0x001 in EXEC; out_valid 2 cycles after accept; out_result=12.
- Store:
  - Stimulus: uop=16, bhwd=100, src1=0x8000_0000, imm=0x10, src2=0xAB.
  - Response: out_result=0x8000_0010, out_sdata=0xABAB_ABAB_ABAB_ABAB.
- DIV:
  - Stimulus: src1=-7, src2=2.
  - Response: Q=-3 after 67 cycles. REM on the same operands gives R=-1.
  - DIVW on src1=0xFFFF_FFFF_8000_0000, src2=-1 gives 0xFFFF_FFFF_8000_0000 (overflow rule) in 3 cycles.
- Divide by zero:
  - DIVU x/0 gives 0xFFFF_FFFF_FFFF_FFFF.
  - REMU 0x1234/0 gives 0x1234.
- Backpressure:
  - Stimulus: out_ready=0 for 10 cycles after out_valid.
  - Response: out_result stable, in_ready=0 throughout; release gives in_ready=1 the next cycle.
- flush/reset:
  - flush mid DIV_LOOP gives IDLE next cycle, out_valid never asserts.
  - rst mid EXEC gives all outputs 0 next cycle and in_ready=1 after release.
